// File: rtl/voq_pkg.sv
// Shared types and address helpers for the VOQ ingress writer.
// Consumed by voq_ingress_port and voq_ingress_writer.
package voq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } in_state_e;

  localparam int RUN_W  = 32;
  localparam int STAT_W = 16;

  function automatic int unsigned ctrl_start(input int unsigned bus_aw);
    return (32'd1 << bus_aw) - 32'd1;
  endfunction

  function automatic int unsigned ctrl_stop(input int unsigned bus_aw);
    return (32'd1 << bus_aw) - 32'd2;
  endfunction

  function automatic int unsigned ctrl_flush(input int unsigned bus_aw);
    return (32'd1 << bus_aw) - 32'd3;
  endfunction

  function automatic int unsigned voq_idx(input int unsigned i, input int unsigned j,
                                          input int unsigned n_ports);
    return i * n_ports + j;
  endfunction

endpackage

// File: rtl/voq_ingress_port.sv
// One ingress channel: header parse, admission, packet FSM and the write
// pointer / occupancy pair for each of its N_PORTS VOQs. Stats under VOQ_STATS_EN.
module voq_ingress_port
  import voq_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int MAX_PKT = 64,
  localparam int CNT_W  = ADDR_W + 1,
  localparam int LEN_W  = $clog2(MAX_PKT + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        wr_vld_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  input  logic [N_PORTS-1:0]          pop_i,
  output logic [N_PORTS-1:0]          wr_en_o,
  output logic [N_PORTS*ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]           wr_data_o,
  output logic [N_PORTS*CNT_W-1:0]    count_o,
  output logic [1:0]                  state_o,
  output logic [LEN_W-1:0]            len_o,
  output logic                        trunc_err_o,
  output logic                        pop_err_o
`ifdef VOQ_STATS_EN
  ,
  output logic [STAT_W-1:0]           pkt_ok_o,
  output logic [STAT_W-1:0]           pkt_drop_o
`endif
);

  localparam int DEST_W = $clog2(N_PORTS);
  localparam int unsigned ADMIT_MAX = (2 ** ADDR_W) - MAX_PKT;

  in_state_e             state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  trunc_q, trunc_d;
  logic                  wr_en_q, wr_en_d;
  logic [DEST_W-1:0]     dest_q, dest_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  pop_err_q;

  logic [CNT_W-1:0]      cnt_w [N_PORTS];
  logic [N_PORTS-1:0]    pop_bad;
  logic [DEST_W-1:0]     dest_hdr;
  logic [CNT_W:0]        occ;
  logic                  admit;

`ifdef VOQ_STATS_EN
  logic [STAT_W-1:0]     ok_q, drop_q;
  logic                  ok_inc, drop_inc;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction
`endif

  // The write still in flight for this dest has not reached cnt yet; count it so
  // back-to-back packets can never over-admit.
  assign dest_hdr = wr_data_i[DEST_W-1:0];
  assign occ      = {1'b0, cnt_w[dest_hdr]} + (CNT_W+1)'(wr_en_q && (dest_q == dest_hdr));
  assign admit    = (occ <= (CNT_W+1)'(ADMIT_MAX));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    wr_en_d = 1'b0;
    dest_d  = dest_q;
    data_d  = wr_data_i;
`ifdef VOQ_STATS_EN
    ok_inc   = 1'b0;
    drop_inc = 1'b0;
`endif
    if (wr_vld_i) begin
      unique case (state_q)
        IDLE: begin
          if (wr_data_i != '0) begin
            dest_d = dest_hdr;
            if (admit) begin
              wr_en_d = 1'b1;
              len_d   = LEN_W'(1);
              state_d = BODY;
            end else begin
              state_d = DROP;
`ifdef VOQ_STATS_EN
              drop_inc = 1'b1;
`endif
            end
          end
        end
        BODY: begin
          if (wr_data_i == '0) begin
            wr_en_d = 1'b1;
            state_d = IDLE;
`ifdef VOQ_STATS_EN
            ok_inc = 1'b1;
`endif
          end else if (len_q < LEN_W'(MAX_PKT - 1)) begin
            wr_en_d = 1'b1;
            len_d   = len_q + LEN_W'(1);
          end else begin
            trunc_d = 1'b1;
          end
        end
        DROP: begin
          if (wr_data_i == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage boundary: bus word -> registered VOQ write strobe
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      trunc_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      dest_q    <= '0;
      pop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      wr_en_q   <= wr_en_d;
      dest_q    <= dest_d;
      pop_err_q <= pop_err_q | (|pop_bad);
    end
    data_q <= data_d;
  end

`ifdef VOQ_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      if (ok_inc)   ok_q   <= sat_inc(ok_q);
      if (drop_inc) drop_q <= sat_inc(drop_q);
    end
  end

  assign pkt_ok_o   = ok_q;
  assign pkt_drop_o = drop_q;
`endif

  for (genvar j = 0; j < N_PORTS; j++) begin : g_voq
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_j, pop_j;

    assign wr_j       = wr_en_q && (dest_q == DEST_W'(j));
    assign pop_j      = pop_i[j] && (cnt_q != '0);
    assign pop_bad[j] = pop_i[j] && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        ptr_q <= '0;
        cnt_q <= '0;
      end else begin
        if (wr_j) ptr_q <= ptr_q + ADDR_W'(1);
        unique case ({wr_j, pop_j})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign cnt_w[j]                     = cnt_q;
    assign wr_en_o[j]                   = wr_j;
    assign wr_addr_o[j*ADDR_W +: ADDR_W] = ptr_q;
    assign count_o[j*CNT_W +: CNT_W]     = cnt_q;
  end

  assign wr_data_o   = data_q;
  assign state_o     = state_q;
  assign len_o       = len_q;
  assign trunc_err_o = trunc_q;
  assign pop_err_o   = pop_err_q;

endmodule

// File: rtl/voq_ingress_writer.sv
// VOQ ingress front end: bus decode, N_PORTS ingress channels, status/run-cycle
// readback and scheduler start pulse. Per-input packet stats under VOQ_STATS_EN.
module voq_ingress_writer
  import voq_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int MAX_PKT = 64,
  parameter int BUS_AW  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  chipselect,
  input  logic                                  write,
  input  logic                                  read,
  input  logic [BUS_AW-1:0]                     address,
  input  logic [DATA_W-1:0]                     writedata,
  output logic [DATA_W-1:0]                     readdata,
  output logic [N_PORTS*N_PORTS-1:0]            voq_wr_en,
  output logic [N_PORTS*N_PORTS*ADDR_W-1:0]     voq_wr_addr,
  output logic [N_PORTS*DATA_W-1:0]             voq_wr_data,
  input  logic [N_PORTS*N_PORTS-1:0]            voq_pop,
  output logic [N_PORTS*N_PORTS*(ADDR_W+1)-1:0] voq_count,
  output logic                                  sched_start
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int LEN_W = $clog2(MAX_PKT + 1);
  localparam logic [BUS_AW-1:0] A_START = BUS_AW'(ctrl_start(BUS_AW));
  localparam logic [BUS_AW-1:0] A_STOP  = BUS_AW'(ctrl_stop(BUS_AW));
  localparam logic [BUS_AW-1:0] A_FLUSH = BUS_AW'(ctrl_flush(BUS_AW));

  logic               bus_wr, bus_rd, flush;
  logic [1:0]         st_w  [N_PORTS];
  logic [LEN_W-1:0]   len_w [N_PORTS];
  logic [N_PORTS-1:0] trunc_w, perr_w;
  logic [DATA_W-1:0]  rd_mux, rdata_q;
  logic [RUN_W-1:0]   run_q;
  logic               run_en_q, start_q;

`ifdef VOQ_STATS_EN
  logic [STAT_W-1:0]  ok_w   [N_PORTS];
  logic [STAT_W-1:0]  drop_w [N_PORTS];
`endif

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + RUN_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] pack_status(input logic pe, input logic te,
                                                    input logic [1:0] st,
                                                    input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] s;
    s                  = '0;
    s[DATA_W-1]        = pe;
    s[DATA_W-2]        = te;
    s[DATA_W-3 -: 2]   = st;
    s[LEN_W-1:0]       = len;
    return s;
  endfunction

  assign bus_wr = chipselect && write;
  assign bus_rd = chipselect && read;
  assign flush  = bus_wr && (address == A_FLUSH);

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    voq_ingress_port #(
      .N_PORTS (N_PORTS),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .MAX_PKT (MAX_PKT)
    ) u_port (
      .clk_i       (clk),
      .rst_i       (reset),
      .flush_i     (flush),
      .wr_vld_i    (bus_wr && (address == BUS_AW'(i))),
      .wr_data_i   (writedata),
      .pop_i       (voq_pop[voq_idx(i, 0, N_PORTS) +: N_PORTS]),
      .wr_en_o     (voq_wr_en[voq_idx(i, 0, N_PORTS) +: N_PORTS]),
      .wr_addr_o   (voq_wr_addr[voq_idx(i, 0, N_PORTS)*ADDR_W +: N_PORTS*ADDR_W]),
      .wr_data_o   (voq_wr_data[i*DATA_W +: DATA_W]),
      .count_o     (voq_count[voq_idx(i, 0, N_PORTS)*CNT_W +: N_PORTS*CNT_W]),
      .state_o     (st_w[i]),
      .len_o       (len_w[i]),
      .trunc_err_o (trunc_w[i]),
      .pop_err_o   (perr_w[i])
`ifdef VOQ_STATS_EN
      ,
      .pkt_ok_o    (ok_w[i]),
      .pkt_drop_o  (drop_w[i])
`endif
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (address == BUS_AW'(i)) rd_mux = pack_status(|perr_w, trunc_w[i], st_w[i], len_w[i]);
`ifdef VOQ_STATS_EN
      if (address == BUS_AW'(int'(ctrl_flush(BUS_AW)) - 1 - i))
        rd_mux = DATA_W'({drop_w[i], ok_w[i]});
`endif
    end
    if (address == A_START) rd_mux = DATA_W'(run_q);
  end

  // Stage boundary: control decode -> start pulse, run counter, read data
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= '0;
      run_en_q <= 1'b0;
      start_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      start_q <= bus_wr && (address == A_START);
      if (bus_wr && (address == A_START)) begin
        run_q    <= '0;
        run_en_q <= 1'b1;
      end else begin
        if (run_en_q) run_q <= sat_inc_run(run_q);
        if (bus_wr && (address == A_STOP)) run_en_q <= 1'b0;
      end
      if (bus_rd) rdata_q <= rd_mux;
    end
  end

  assign readdata    = rdata_q;
  assign sched_start = start_q;

endmodule

// File: tb/tb_voq_ingress_writer.sv
// Directed bench for voq_ingress_writer with a write scoreboard on the VOQ ports.
module tb_voq_ingress_writer;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int MP  = 64;
  localparam int BAW = 4;
  localparam int NV  = N * N;
  localparam int CW  = AW + 1;

  logic              clk = 1'b0;
  logic              reset, chipselect, write, read;
  logic [BAW-1:0]    address;
  logic [DW-1:0]     writedata, readdata;
  logic [NV-1:0]     voq_wr_en, voq_pop;
  logic [NV*AW-1:0]  voq_wr_addr;
  logic [N*DW-1:0]   voq_wr_data;
  logic [NV*CW-1:0]  voq_count;
  logic              sched_start;

  always #5 clk = ~clk;

  voq_ingress_writer #(
    .N_PORTS (N), .DATA_W (DW), .ADDR_W (AW), .MAX_PKT (MP), .BUS_AW (BAW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .voq_wr_en   (voq_wr_en),
    .voq_wr_addr (voq_wr_addr),
    .voq_wr_data (voq_wr_data),
    .voq_pop     (voq_pop),
    .voq_count   (voq_count),
    .sched_start (sched_start)
  );

  typedef struct {
    int          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int          t;
  } exp_t;

  exp_t          sb [$];
  logic [AW-1:0] eptr [NV];
  int            total = 0;
  int            bad   = 0;
  int            negcnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int v);
    return voq_count[v*CW +: CW];
  endfunction

  always @(negedge clk) begin
    negcnt++;
    for (int v = 0; v < NV; v++) begin
      if (voq_wr_en[v] !== 1'b0) begin
        chk("wr_expected_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_voq", v, e.v);
          chk("wr_addr", voq_wr_addr[v*AW +: AW], e.a);
          chk("wr_data", voq_wr_data[(v/N)*DW +: DW], e.d);
          chk("wr_cycle", negcnt, e.t);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chan_write(input int ch, input int dest, input logic [DW-1:0] w, input bit exp_wr);
    int v;
    exp_t e;
    chipselect = 1'b1; write = 1'b1; address = BAW'(ch); writedata = w;
    if (exp_wr) begin
      v   = ch * N + dest;
      e.v = v; e.a = eptr[v]; e.d = w; e.t = negcnt + 2;
      sb.push_back(e);
      eptr[v] = eptr[v] + AW'(1);
    end
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_ctl(input int a);
    chipselect = 1'b1; write = 1'b1; address = BAW'(a); writedata = '0;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [DW-1:0] d);
    chipselect = 1'b1; read = 1'b1; address = BAW'(a);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic send_pkt(input int ch, input int dest, input int nwords);
    chan_write(ch, dest, 32'hA500 | DW'(dest), 1'b1);
    for (int k = 1; k <= nwords - 2; k++) chan_write(ch, dest, 32'h1000 + DW'(k), 1'b1);
    chan_write(ch, dest, '0, 1'b1);
  endtask

  task automatic pop_for(input int v, input int n);
    voq_pop[v] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    voq_pop[v] = 1'b0;
  endtask

  task automatic clear_model();
    for (int v = 0; v < NV; v++) eptr[v] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    clear_model();
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; voq_pop = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", voq_wr_en, 0);
    chk("rst_sched_start", sched_start, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_count_zero", 64'(voq_count == '0), 64'd1);
    reset = 1'b0;
    idle(1);
    bus_read(0, rd);
    chk("rst_status0", rd, 0);
    bus_read(15, rd);
    chk("rst_run_cycles", rd, 0);

    // Basic packet on ch0 to VOQ(0,1)
    chan_write(0, 1, 32'h1, 1'b1);
    chan_write(0, 1, 32'hA, 1'b1);
    chan_write(0, 1, 32'hB, 1'b1);
    chan_write(0, 1, 32'h0, 1'b1);
    idle(2);
    chk("t1_count01", cnt(1), 4);
    bus_read(0, rd);
    chk("t1_state_idle", rd[29:28], 0);
    chk("t1_len", rd[6:0], 3);
    chan_write(0, 1, 32'h0, 1'b0);
    idle(2);
    chk("t1_idle_zero_ignored", cnt(1), 4);

    // Write and pop on VOQ(1,0) in the same cycle, then pop underflow
    chan_write(1, 0, 32'h4, 1'b1);
    for (int k = 5; k <= 8; k++) chan_write(1, 0, DW'(k), 1'b1);
    chan_write(1, 0, 32'h9, 1'b1);
    voq_pop[4] = 1'b1;
    @(posedge clk); #1;
    voq_pop[4] = 1'b0;
    idle(1);
    chk("pop_wr_same_cycle", cnt(4), 5);
    chan_write(1, 0, 32'h0, 1'b1);
    idle(2);
    chk("pop_pre_count", cnt(4), 6);
    pop_for(4, 6);
    chk("pop_drained", cnt(4), 0);
    bus_read(1, rd);
    chk("pop_err_clear", rd[31], 0);
    pop_for(4, 1);
    idle(1);
    chk("pop_empty_count", cnt(4), 0);
    bus_read(1, rd);
    chk("pop_err_set", rd[31], 1);
    bus_read(0, rd);
    chk("pop_err_global", rd[31], 1);

    // Flush clears pointers, counts and sticky errors
    bus_ctl(13);
    clear_model();
    chk("flush_count_zero", 64'(voq_count == '0), 64'd1);
    bus_read(1, rd);
    chk("flush_status1", rd, 0);
    send_pkt(0, 1, 4);
    idle(2);
    chk("flush_reuse_count", cnt(1), 4);

    // Truncation on ch2
    chan_write(2, 2, 32'hA502, 1'b1);
    for (int k = 1; k <= 70; k++) chan_write(2, 2, 32'h2000 + DW'(k), k <= 62);
    chan_write(2, 2, 32'h0, 1'b1);
    idle(2);
    chk("trunc_count", cnt(10), 64);
    bus_read(2, rd);
    chk("trunc_err", rd[30], 1);
    chk("trunc_len", rd[6:0], 63);
    chk("trunc_state", rd[29:28], 0);

    // Fill VOQ(3,2) to 4040, then a header must be dropped
    repeat (63) send_pkt(3, 2, 64);
    send_pkt(3, 2, 8);
    idle(2);
    chk("fill_count32", cnt(14), 4040);
    chan_write(3, 2, 32'hA502, 1'b0);
    bus_read(3, rd);
    chk("drop_state", rd[29:28], 2);
    chan_write(3, 2, 32'h77, 1'b0);
    chan_write(3, 2, 32'h0, 1'b0);
    idle(2);
    bus_read(3, rd);
    chk("drop_exit_state", rd[29:28], 0);
    chk("drop_count_kept", cnt(14), 4040);
    send_pkt(3, 0, 3);
    idle(2);
    chk("after_drop_admit", cnt(12), 3);

    // Pointer wrap on VOQ(1,1)
    repeat (63) send_pkt(1, 1, 64);
    idle(2);
    chk("wrap_fill", cnt(5), 4032);
    pop_for(5, 4032);
    chk("wrap_drained", cnt(5), 0);
    send_pkt(1, 1, 63);
    chan_write(1, 1, 32'hA501, 1'b1);
    chan_write(1, 1, 32'h55, 1'b1);
    chan_write(1, 1, 32'h0, 1'b1);
    idle(2);
    chk("wrap_count", cnt(5), 66);
    chk("wrap_model_ptr", eptr[5], 2);

    // run_cycles
    bus_ctl(15);
    chk("start_pulse_hi", sched_start, 1);
    idle(1);
    chk("start_pulse_lo", sched_start, 0);
    idle(98);
    bus_ctl(14);
    bus_read(15, rd);
    chk("run_cycles", rd, 100);
    idle(10);
    bus_read(15, rd);
    chk("run_cycles_frozen", rd, 100);

    // Stats on ch0: 66 good packets, one drop
    bus_ctl(13);
    clear_model();
    repeat (63) send_pkt(0, 3, 64);
    send_pkt(0, 3, 8);
    chan_write(0, 3, 32'hA503, 1'b0);
    chan_write(0, 3, 32'h0, 1'b0);
    send_pkt(0, 1, 4);
    send_pkt(0, 1, 5);
    idle(2);
    chk("stats_fill_count", cnt(3), 4040);
    bus_read(12, rd);
`ifdef VOQ_STATS_EN
    chk("stats_ch0", rd, {16'd1, 16'd66});
`else
    chk("stats_ch0_absent", rd, 0);
`endif
    bus_read(11, rd);
    chk("stats_ch1", rd, 0);
    bus_read(7, rd);
    chk("unmapped_read", rd, 0);

    idle(3);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voq_ingress_writer.md
Name: voq_ingress_writer

Overview:
- Parametrised successor to the switch's 4x4 packet ingress front end.
- Accepts bus-written packet words on N_PORTS input channels and parses headers to pick the output port.
- Writes each packet into one of N_PORTS*N_PORTS virtual output queue (VOQ) RAMs through write-side ports.
- Tracks per-VOQ occupancy against scheduler pops and drops packets that cannot fit.

Parameters:
- N_PORTS, 4: input and output port count (power of 2, 2..8).
- DATA_W, 32: packet word width.
- ADDR_W, 12: VOQ RAM address width; depth = 2**ADDR_W.
- MAX_PKT, 64: maximum packet length in words, header and terminator included.
- BUS_AW, 4: bus address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- chipselect  in  1  bus select.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- address  in  BUS_AW  register/channel select.
- writedata  in  DATA_W  bus write data.
- readdata  out  DATA_W  registered read data.
- voq_wr_en  out  N_PORTS*N_PORTS  per-VOQ write enable; index i*N_PORTS+j.
- voq_wr_addr  out  N_PORTS*N_PORTS*ADDR_W  per-VOQ write address.
- voq_wr_data  out  N_PORTS*DATA_W  per-input data, shared by that input's VOQs.
- voq_pop  in  N_PORTS*N_PORTS  scheduler consumed one word from the VOQ.
- voq_count  out  N_PORTS*N_PORTS*(ADDR_W+1)  per-VOQ occupancy.
- sched_start  out  1  one-cycle pulse on a CTRL_START write.

Behaviour:
- Reset values:
  - All write pointers, counts, voq_wr_en, readdata and sched_start are 0.
  - All input FSMs are in IDLE; run_cycles is 0.
- Channel write: chipselect&&write with address i<N_PORTS delivers a word to input i. One word per cycle per bus; channels are independent.
- Input FSM states:
  - IDLE:
    - Zero word is ignored.
    - Nonzero word is a header; dest = writedata[log2(N_PORTS)-1:0].
    - If free(i,dest) = 2**ADDR_W - count(i,dest) >= MAX_PKT: write the header, set len=1, go to BODY. Otherwise go to DROP.
  - BODY:
    - Nonzero word with len < MAX_PKT-1 is written and len increments.
    - Nonzero word with len = MAX_PKT-1 is discarded and trunc_err(i) sets (sticky).
    - Zero word is written as the terminator, then go to IDLE.
  - DROP:
    - Nonzero words are discarded.
    - A zero word returns the FSM to IDLE and is not written.
- Write timing:
  - voq_wr_en(i,dest) is high exactly one cycle, in the cycle after the bus write.
  - voq_wr_addr = wr_ptr(i,dest) and voq_wr_data(i) = the word in that same cycle.
  - wr_ptr increments that cycle and wraps at 2**ADDR_W.
- Occupancy:
  - Write alone: count +1. Pop alone: count -1. Write and pop in the same cycle: count unchanged.
  - Pop with count=0 is ignored and sets pop_err (sticky).
  - Overflow is impossible by construction (admission reserves MAX_PKT words).
- Control addresses (constants in package):
  - CTRL_START = 2**BUS_AW-1: pulses sched_start, clears and enables run_cycles.
  - CTRL_STOP = 2**BUS_AW-2: freezes run_cycles.
  - CTRL_FLUSH = 2**BUS_AW-3: next cycle zeroes all wr_ptr and count, returns FSMs to IDLE, clears sticky errors.
- Flush conflicts: flush wins over simultaneous channel writes and pops. Channel writes in the flush cycle are lost.
- run_cycles: 32-bit, increments each cycle while enabled, saturates at all-ones.
- Reads: readdata is valid one cycle after chipselect&&read.
  - Address i<N_PORTS returns {pop_err, trunc_err(i), state(i)[1:0], zero-pad, len(i)}.
  - CTRL_START returns run_cycles.
  - Any other address returns 0.
- Reset mid-packet: all state clears; the partial packet already written stays in RAM but count=0 hides it.

Optional Feature:
- Macro VOQ_STATS_EN.
- Defined: per-input 16-bit saturating counters pkt_ok (terminator written) and pkt_drop (DROP entered). Read at CTRL_FLUSH-1-i as {pkt_drop, pkt_ok}. Cleared by reset and flush.
- Undefined: the counters do not exist and those addresses read 0.

Decomposition:
- Package voq_pkg: state enum (IDLE, BODY, DROP), CTRL_* address functions of BUS_AW, index helper voq_idx(i,j).
- Sub-module voq_ingress_port, instantiated N_PORTS times by generate. Holds one input FSM, len, trunc_err and N_PORTS pointer/count pairs.
- The top holds bus decode, read mux, run_cycles and sched_start.

Test Plan:
- Write 0x1, 0xA, 0xB, 0x0 on ch0 -> writes to VOQ(0,1) at addrs 0..3 on consecutive cycles; count(0,1)=4; ch0 state IDLE.
- Header 0x2 on ch3 with count(3,2)=4040 (free 56 < 64) -> no voq_wr_en; DROP until 0x0; status reads state=DROP before the terminator.
- Send 70 nonzero words then 0x0 on ch2 -> 63 words written plus terminator (64), trunc_err(2)=1.
- Write and pop on VOQ(1,0) in the same cycle with count=5 -> count stays 5; pop on an empty VOQ -> pop_err=1, count 0.
- Fill wr_ptr to 4095 then write 2 words -> addresses 4095, 0.
- Write CTRL_START, wait 100 cycles, write CTRL_STOP, read CTRL_START -> 100 (±1 per the documented edge). With VOQ_STATS_EN, after two good packets and one dropped packet on ch0 -> {1,2}.
